axil_slave_regfile: RTL and testbench

AXI4-Lite slave exposing a bank of 32-bit read/write control registers to the fabric; it is the downstream endpoint driven by the team's AXI4-Lite master. It accepts independent write-address, write-data and read-address channels, and returns OKAY or DECERR responses. Register contents and per-register write strobes are exported to the surrounding logic.

---
 rtl/axil_pkg.sv | 24 ++
 rtl/axil_slave_regfile_if.sv | 38 +++
 rtl/axil_slave_regfile.sv | 138 +++++++++++++
 tb/tb_axil_slave_regfile.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes and the register-bank address decoder.
package axil_pkg;

    typedef logic [1:0] resp_t;

    localparam resp_t OKAY   = 2'b00;
    localparam resp_t EXOKAY = 2'b01;
    localparam resp_t SLVERR = 2'b10;
    localparam resp_t DECERR = 2'b11;

    typedef struct packed {
        logic       in_range;
        logic [7:0] index;
    } dec_t;

    // Word index comes from addr[log2(num_regs)+1:2]; byte offset bits are ignored.
    function automatic dec_t axil_decode(input logic [63:0] addr, input int unsigned num_regs);
        dec_t d;
        d.in_range = (addr < (64'(num_regs) << 2));
        d.index    = 8'((addr >> 2) & 64'(num_regs - 1));
        return d;
    endfunction

endpackage

// File: rtl/axil_slave_regfile_if.sv
// AXI4-Lite bus bundle between the fabric master and the register-file slave.
interface axil_slave_regfile_if #(
    parameter int unsigned ADDR_W = 32
);

    logic [ADDR_W-1:0] S_AXI_AWADDR;
    logic              S_AXI_AWVALID;
    logic              S_AXI_AWREADY;
    logic [31:0]       S_AXI_WDATA;
    logic [3:0]        S_AXI_WSTRB;
    logic              S_AXI_WVALID;
    logic              S_AXI_WREADY;
    logic [1:0]        S_AXI_BRESP;
    logic              S_AXI_BVALID;
    logic              S_AXI_BREADY;
    logic [ADDR_W-1:0] S_AXI_ARADDR;
    logic              S_AXI_ARVALID;
    logic              S_AXI_ARREADY;
    logic [31:0]       S_AXI_RDATA;
    logic [1:0]        S_AXI_RRESP;
    logic              S_AXI_RVALID;
    logic              S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
               S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
               S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
               S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
               S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

endinterface

// File: rtl/axil_slave_regfile.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit control registers with OKAY/DECERR responses.
// Define AXIL_REGFILE_WSTRB_EN to honour WSTRB byte lanes; otherwise every write is full-word.
module axil_slave_regfile
    import axil_pkg::*;
#(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned ADDR_W   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    axil_slave_regfile_if.slave      s_axi,
    output logic [NUM_REGS*32-1:0]   regs_o,
    output logic [NUM_REGS-1:0]      wr_pulse_o
);

    localparam int unsigned IDX_W = $clog2(NUM_REGS);

    logic              active;
    logic              aw_held, w_held, bvalid, rvalid;
    logic [ADDR_W-1:0] aw_addr_q;
    logic [31:0]       w_data_q, rdata;
    resp_t             bresp, rresp;
    logic [31:0]       regs [NUM_REGS];
    dec_t              wr_dec, rd_dec;
    logic [IDX_W-1:0]  wr_idx, rd_idx;
    logic [31:0]       wr_mask;
    logic              aw_hs, w_hs, ar_hs, commit;
    logic              unused_bits;

    assign s_axi.S_AXI_AWREADY = active & ~aw_held & ~bvalid;
    assign s_axi.S_AXI_WREADY  = active & ~w_held & ~bvalid;
    assign s_axi.S_AXI_ARREADY = active & ~rvalid;
    assign s_axi.S_AXI_BVALID  = bvalid;
    assign s_axi.S_AXI_BRESP   = bresp;
    assign s_axi.S_AXI_RVALID  = rvalid;
    assign s_axi.S_AXI_RRESP   = rresp;
    assign s_axi.S_AXI_RDATA   = rdata;

    assign aw_hs  = s_axi.S_AXI_AWVALID & s_axi.S_AXI_AWREADY;
    assign w_hs   = s_axi.S_AXI_WVALID & s_axi.S_AXI_WREADY;
    assign ar_hs  = s_axi.S_AXI_ARVALID & s_axi.S_AXI_ARREADY;
    assign commit = aw_held & w_held;

    always_comb begin
        wr_dec = axil_decode(64'(aw_addr_q), NUM_REGS);
        rd_dec = axil_decode(64'(s_axi.S_AXI_ARADDR), NUM_REGS);
        wr_idx = wr_dec.index[IDX_W-1:0];
        rd_idx = rd_dec.index[IDX_W-1:0];
    end

`ifdef AXIL_REGFILE_WSTRB_EN
    logic [3:0] w_strb_q;

    always_comb begin
        wr_mask = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            wr_mask[8*k +: 8] = {8{w_strb_q[k]}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       w_strb_q <= '0;
        else if (w_hs) w_strb_q <= s_axi.S_AXI_WSTRB;
    end

    assign unused_bits = ^{wr_dec.index, rd_dec.index};
`else
    assign wr_mask     = '1;
    assign unused_bits = ^{wr_dec.index, rd_dec.index, s_axi.S_AXI_WSTRB};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) active <= 1'b0;
        else     active <= 1'b1;
    end

    // Holds can only fill while BVALID is low, so commit never overlaps a handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            bvalid    <= 1'b0;
            bresp     <= OKAY;
        end else begin
            if (aw_hs) begin
                aw_held   <= 1'b1;
                aw_addr_q <= s_axi.S_AXI_AWADDR;
            end
            if (w_hs) begin
                w_held   <= 1'b1;
                w_data_q <= s_axi.S_AXI_WDATA;
            end
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bvalid  <= 1'b1;
                bresp   <= wr_dec.in_range ? OKAY : DECERR;
            end else if (bvalid && s_axi.S_AXI_BREADY) begin
                bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            wr_pulse_o <= '0;
        end else begin
            wr_pulse_o <= '0;
            if (commit && wr_dec.in_range) begin
                regs[wr_idx]       <= (regs[wr_idx] & ~wr_mask) | (w_data_q & wr_mask);
                wr_pulse_o[wr_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            rresp  <= OKAY;
        end else if (ar_hs) begin
            rvalid <= 1'b1;
            rdata  <= rd_dec.in_range ? regs[rd_idx] : '0;
            rresp  <= rd_dec.in_range ? OKAY : DECERR;
        end else if (rvalid && s_axi.S_AXI_RREADY) begin
            rvalid <= 1'b0;
        end
    end

    always_comb begin
        regs_o = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) regs_o[32*i +: 32] = regs[i];
    end

endmodule

// File: tb/tb_axil_slave_regfile.sv
// Directed bench for axil_slave_regfile (NUM_REGS=16): vector table plus handshake corner sequences.
module tb_axil_slave_regfile;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [511:0] regs_o;
    logic [15:0]  wr_pulse_o;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_regs [16];

    axil_slave_regfile_if #(.ADDR_W(32)) bus ();

    axil_slave_regfile #(.NUM_REGS(16), .ADDR_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_axi      (bus),
        .regs_o     (regs_o),
        .wr_pulse_o (wr_pulse_o)
    );

    always #5 clk = ~clk;

`ifdef AXIL_REGFILE_WSTRB_EN
    localparam logic [31:0] EXP_LANE0 = 32'hDEADBEAA;
    localparam logic [31:0] EXP_NOSTRB = 32'h0000_0000;
`else
    localparam logic [31:0] EXP_LANE0 = 32'h0000_00AA;
    localparam logic [31:0] EXP_NOSTRB = 32'h1122_3344;
`endif

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] exp;
        logic [15:0] pulse;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] flat_exp();
        logic [511:0] f;
        for (int i = 0; i < 16; i++) f[32*i +: 32] = exp_regs[i];
        return f;
    endfunction

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input bit hold_b, output logic [1:0] resp, output logic [15:0] pulse);
        int  n;
        bit  aw_f, w_f;
        bus.S_AXI_AWADDR  = addr;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA   = data;
        bus.S_AXI_WSTRB   = strb;
        bus.S_AXI_WVALID  = 1'b1;
        n = 0;
        while ((bus.S_AXI_AWVALID || bus.S_AXI_WVALID) && n < 20) begin
            aw_f = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
            w_f  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
            tick();
            n++;
            if (aw_f) bus.S_AXI_AWVALID = 1'b0;
            if (w_f)  bus.S_AXI_WVALID  = 1'b0;
        end
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        n = 0;
        while (!bus.S_AXI_BVALID && n < 20) begin
            tick();
            n++;
        end
        if (!bus.S_AXI_BVALID) check("bvalid_timeout", 512'(bus.S_AXI_BVALID), 512'd1);
        resp  = bus.S_AXI_BRESP;
        pulse = wr_pulse_o;
        if (!hold_b) begin
            bus.S_AXI_BREADY = 1'b1;
            tick();
            bus.S_AXI_BREADY = 1'b0;
        end
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        bit f;
        bus.S_AXI_ARADDR  = addr;
        bus.S_AXI_ARVALID = 1'b1;
        n = 0;
        while (bus.S_AXI_ARVALID && n < 20) begin
            f = bus.S_AXI_ARREADY;
            tick();
            n++;
            if (f) bus.S_AXI_ARVALID = 1'b0;
        end
        bus.S_AXI_ARVALID = 1'b0;
        n = 0;
        while (!bus.S_AXI_RVALID && n < 20) begin
            tick();
            n++;
        end
        if (!bus.S_AXI_RVALID) check("rvalid_timeout", 512'(bus.S_AXI_RVALID), 512'd1);
        data = bus.S_AXI_RDATA;
        resp = bus.S_AXI_RRESP;
        bus.S_AXI_RREADY = 1'b1;
        tick();
        bus.S_AXI_RREADY = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  resp;
        logic [15:0] pulse;
        logic [31:0] rd;

        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA = '0;  bus.S_AXI_WSTRB = '0; bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_ARADDR = '0; bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b0;
        for (int i = 0; i < 16; i++) exp_regs[i] = '0;

        vecs.push_back('{1'b1, 32'h08,  32'hDEADBEEF, 4'hF, 2'b00, 32'hDEADBEEF, 16'h0004});
        vecs.push_back('{1'b0, 32'h08,  32'h0,        4'h0, 2'b00, 32'hDEADBEEF, 16'h0000});
        vecs.push_back('{1'b0, 32'h04,  32'h0,        4'h0, 2'b00, 32'h12345678, 16'h0000});
        vecs.push_back('{1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, 2'b11, 32'h0,        16'h0000});
        vecs.push_back('{1'b0, 32'h100, 32'h0,        4'h0, 2'b11, 32'h0,        16'h0000});
        vecs.push_back('{1'b1, 32'h3C,  32'hA5A5A5A5, 4'hF, 2'b00, 32'hA5A5A5A5, 16'h8000});
        vecs.push_back('{1'b0, 32'h3F,  32'h0,        4'h0, 2'b00, 32'hA5A5A5A5, 16'h0000});
        vecs.push_back('{1'b0, 32'h40,  32'h0,        4'h0, 2'b11, 32'h0,        16'h0000});
        vecs.push_back('{1'b1, 32'h0B,  32'h000000AA, 4'h1, 2'b00, EXP_LANE0,    16'h0004});
        vecs.push_back('{1'b0, 32'h08,  32'h0,        4'h0, 2'b00, EXP_LANE0,    16'h0000});
        vecs.push_back('{1'b1, 32'h0C,  32'h11223344, 4'h0, 2'b00, EXP_NOSTRB,   16'h0008});
        vecs.push_back('{1'b0, 32'h0C,  32'h0,        4'h0, 2'b00, EXP_NOSTRB,   16'h0000});
        vecs.push_back('{1'b0, 32'h00,  32'h0,        4'h0, 2'b00, 32'h0,        16'h0000});

        // Reset state, then READY only after the first edge past deassertion
        repeat (3) tick();
        check("reset_ready", 512'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}), 512'd0);
        check("reset_valid_resp", 512'({bus.S_AXI_BVALID, bus.S_AXI_RVALID, bus.S_AXI_BRESP, bus.S_AXI_RRESP}), 512'd0);
        check("reset_rdata", 512'(bus.S_AXI_RDATA), 512'd0);
        check("reset_regs", regs_o, 512'd0);
        check("reset_pulse", 512'(wr_pulse_o), 512'd0);
        rst = 1'b0;
        #1;
        check("ready_before_active", 512'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}), 512'd0);
        tick();
        check("ready_after_active", 512'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}), 512'h7);

        // W three cycles ahead of AW
        bus.S_AXI_WDATA = 32'h12345678; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
        check("w_first_wready", 512'(bus.S_AXI_WREADY), 512'd1);
        tick();
        bus.S_AXI_WVALID = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("w_held_ready", 512'({bus.S_AXI_WREADY, bus.S_AXI_AWREADY, bus.S_AXI_BVALID}), 512'b010);
            tick();
        end
        bus.S_AXI_AWADDR = 32'h04; bus.S_AXI_AWVALID = 1'b1;
        tick();
        bus.S_AXI_AWVALID = 1'b0;
        check("w_first_no_early_commit", 512'({bus.S_AXI_BVALID, regs_o[63:32]}), 512'd0);
        tick();
        check("w_first_reg1", 512'(regs_o[63:32]), 512'h12345678);
        check("w_first_b", 512'({bus.S_AXI_BVALID, bus.S_AXI_BRESP}), 512'b100);
        check("w_first_pulse", 512'(wr_pulse_o), 512'h0002);
        exp_regs[1] = 32'h12345678;
        bus.S_AXI_BREADY = 1'b1;
        tick();
        bus.S_AXI_BREADY = 1'b0;
        check("w_first_pulse_clear", 512'({bus.S_AXI_BVALID, wr_pulse_o}), 512'd0);

        foreach (vecs[i]) begin
            if (vecs[i].is_wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 1'b0, resp, pulse);
                if (vecs[i].addr < 32'h40) exp_regs[vecs[i].addr[5:2]] = vecs[i].exp;
                check($sformatf("vec%0d_bresp", i), 512'(resp), 512'(vecs[i].resp));
                check($sformatf("vec%0d_pulse", i), 512'(pulse), 512'(vecs[i].pulse));
                check($sformatf("vec%0d_regs", i), regs_o, flat_exp());
            end else begin
                axi_read(vecs[i].addr, rd, resp);
                check($sformatf("vec%0d_rdata", i), 512'(rd), 512'(vecs[i].exp));
                check($sformatf("vec%0d_rresp", i), 512'(resp), 512'(vecs[i].resp));
            end
        end

        // Read held with RREADY low
        bus.S_AXI_ARADDR = 32'h08; bus.S_AXI_ARVALID = 1'b1;
        tick();
        bus.S_AXI_ARVALID = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check("rhold_stable", 512'({bus.S_AXI_RVALID, bus.S_AXI_ARREADY, bus.S_AXI_RRESP, bus.S_AXI_RDATA}),
                  512'({1'b1, 1'b0, 2'b00, exp_regs[2]}));
            tick();
        end
        bus.S_AXI_RREADY = 1'b1;
        tick();
        bus.S_AXI_RREADY = 1'b0;
        check("rhold_release", 512'({bus.S_AXI_RVALID, bus.S_AXI_ARREADY}), 512'b01);

        // Read and write commit to reg15 on the same edge: read sees the old value
        bus.S_AXI_AWADDR = 32'h3C; bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA = 32'h0F0F0F0F; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
        tick();
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_ARADDR = 32'h3C; bus.S_AXI_ARVALID = 1'b1;
        tick();
        bus.S_AXI_ARVALID = 1'b0;
        check("rw_same_edge_rdata", 512'({bus.S_AXI_RVALID, bus.S_AXI_RDATA}), 512'({1'b1, 32'hA5A5A5A5}));
        check("rw_same_edge_reg15", 512'({bus.S_AXI_BVALID, regs_o[511:480]}), 512'({1'b1, 32'h0F0F0F0F}));
        exp_regs[15] = 32'h0F0F0F0F;
        bus.S_AXI_BREADY = 1'b1; bus.S_AXI_RREADY = 1'b1;
        tick();
        bus.S_AXI_BREADY = 1'b0; bus.S_AXI_RREADY = 1'b0;

        // Reset while BVALID is pending
        axi_write(32'h14, 32'h55AA55AA, 4'hF, 1'b1, resp, pulse);
        check("pre_rst_bvalid_reg5", 512'({bus.S_AXI_BVALID, regs_o[191:160]}), 512'({1'b1, 32'h55AA55AA}));
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_state", 512'({bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY,
                                     bus.S_AXI_ARREADY, wr_pulse_o}), 512'd0);
        check("mid_rst_regs", regs_o, 512'd0);
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_ready_low", 512'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}), 512'd0);
        tick();
        check("post_rst_ready_high", 512'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY, bus.S_AXI_BVALID}),
              512'b1110);
        axi_read(32'h14, rd, resp);
        check("post_rst_no_replay", 512'({resp, rd}), 512'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
